// File: rtl/fire_scheduler_if.sv
// Firing interface between the scheduler and the circuit model it drives.
// master = scheduler side, slave = circuit/environment side.
interface fire_scheduler_if #(
  parameter int N        = 8,
  parameter int FIREBITS = 4,
  parameter int CNT_W    = 16
);
  logic [N-1:0]        excited;
  logic [N-1:0]        allow;
  logic                hold;
  logic [FIREBITS-1:0] fire;
  logic                fire_valid;
  logic                deadlock;
  logic [CNT_W-1:0]    fire_count;
  logic [CNT_W-1:0]    idle_count;

  // No backpressure: the circuit consumes `fire` every cycle; fire_valid
  // qualifies it (fire == N means idle and enables no DFF).
  modport master (
    input  excited, allow, hold,
    output fire, fire_valid, deadlock, fire_count, idle_count
  );

  modport slave (
    output excited, allow, hold,
    input  fire, fire_valid, deadlock, fire_count, idle_count
  );
endinterface

// File: rtl/fire_scheduler.sv
// Round-robin firing scheduler for a performance circuit model, with
// an allow-mask, hold, saturating perf counters and a sticky deadlock flag.
module fire_scheduler #(
    parameter int N           = 8,
    parameter int FIREBITS    = 4,
    parameter int CNT_W       = 16,
    parameter int BLOCK_LIMIT = 16
) (
    input logic        clk,
    input logic        reset,
    fire_scheduler_if.master bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = $clog2(BLOCK_LIMIT + 1);
    localparam logic [FIREBITS-1:0] IDLE = FIREBITS'(N);

    logic [FIREBITS-1:0] fire_r;
    logic                valid_r;
    logic                deadlock_r;
    logic [CNT_W-1:0]    fire_cnt_r;
    logic [CNT_W-1:0]    idle_cnt_r;
    logic [PW-1:0]       ptr_r;
    logic [BW-1:0]       blk_cnt_r;

    logic [N-1:0]        last;
    logic [N-1:0]        cand;
    logic [N-1:0]        pending;
    logic [2*N-1:0]      rot;
    logic                found;
    logic [FIREBITS-1:0] sel;
    int                  idx;

    // The index on `fire` is still excited until its DFF toggles at the next
    // edge, so it must be masked or it would be fired (toggled) twice.
    always_comb begin
        last    = valid_r ? (N'(1) << fire_r) : '0;
        cand    = bus.excited & bus.allow & ~last;
        pending = bus.excited & ~last;
        rot     = {cand, cand} >> ptr_r;
        found   = 1'b0;
        sel     = IDLE;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                idx   = int'(ptr_r) + i;
                if (idx >= N) idx = idx - N;
                sel   = FIREBITS'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fire_r     <= IDLE;
            valid_r    <= 1'b0;
            deadlock_r <= 1'b0;
            fire_cnt_r <= '0;
            idle_cnt_r <= '0;
            ptr_r      <= '0;
            blk_cnt_r  <= '0;
        end else if (bus.hold) begin
            fire_r  <= IDLE;
            valid_r <= 1'b0;
        end else if (found) begin
            fire_r    <= sel;
            valid_r   <= 1'b1;
            ptr_r     <= (sel == FIREBITS'(N - 1)) ? '0 : PW'(sel + 1'b1);
            blk_cnt_r <= '0;
            if (fire_cnt_r != '1) fire_cnt_r <= fire_cnt_r + 1'b1;
        end else begin
            fire_r  <= IDLE;
            valid_r <= 1'b0;
            if (idle_cnt_r != '1) idle_cnt_r <= idle_cnt_r + 1'b1;
            // Work is pending but nothing is allowed: count toward deadlock.
            if (|pending) begin
                if (blk_cnt_r != BW'(BLOCK_LIMIT)) blk_cnt_r <= blk_cnt_r + 1'b1;
                if (blk_cnt_r >= BW'(BLOCK_LIMIT - 1)) deadlock_r <= 1'b1;
            end else begin
                blk_cnt_r <= '0;
            end
        end
    end

    assign bus.fire       = fire_r;
    assign bus.fire_valid = valid_r;
    assign bus.deadlock   = deadlock_r;
    assign bus.fire_count = fire_cnt_r;
    assign bus.idle_count = idle_cnt_r;
endmodule

// File: tb/tb_fire_scheduler.sv
// Scoreboard bench for fire_scheduler: directed and random stimulus checked
// against a spec-level model, on a 16-bit-counter and a 4-bit-counter DUT.
module tb_fire_scheduler;
  localparam int N = 8;
  localparam int LIMIT = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fire_scheduler_if #(.N(N), .FIREBITS(4), .CNT_W(16)) bus_a ();
  fire_scheduler_if #(.N(N), .FIREBITS(4), .CNT_W(4))  bus_b ();

  fire_scheduler #(.N(N), .FIREBITS(4), .CNT_W(16), .BLOCK_LIMIT(LIMIT)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  fire_scheduler #(.N(N), .FIREBITS(4), .CNT_W(4), .BLOCK_LIMIT(LIMIT)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  typedef struct {
    int fire;
    bit dl;
    int fc;
    int ic;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: counters are unbounded; saturation is min().
  int m_fire = N;
  int m_ptr = 0;
  int m_fc = 0;
  int m_ic = 0;
  int m_blk = 0;
  bit m_dl = 0;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model(input logic [7:0] e, input logic [7:0] a, input bit h, input bit r);
    logic [7:0] last, cand;
    int pick;
    if (r) begin
      m_fire = N; m_ptr = 0; m_fc = 0; m_ic = 0; m_blk = 0; m_dl = 0;
    end else if (h) begin
      m_fire = N;
    end else begin
      last = (m_fire < N) ? (8'd1 << m_fire) : 8'd0;
      cand = e & a & ~last;
      pick = -1;
      for (int k = 0; k < N; k++) begin
        if (pick < 0 && cand[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
      end
      if (pick >= 0) begin
        m_fire = pick; m_ptr = (pick + 1) % N; m_fc++; m_blk = 0;
      end else begin
        m_fire = N; m_ic++;
        if ((e & ~last) != 0) begin
          m_blk++;
          if (m_blk >= LIMIT) m_dl = 1;
        end else begin
          m_blk = 0;
        end
      end
    end
    exp_q.push_back('{fire: m_fire, dl: m_dl, fc: m_fc, ic: m_ic});
  endtask

  task automatic step(input logic [7:0] e, input logic [7:0] a, input bit h, input bit r);
    @(negedge clk);
    reset = r;
    bus_a.excited = e; bus_a.allow = a; bus_a.hold = h;
    bus_b.excited = e; bus_b.allow = a; bus_b.hold = h;
    model(e, a, h, r);
  endtask

  // Monitor: the DUT presents a decision every cycle; compare after each edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("fire",         bus_a.fire,       x.fire);
        check("fire_valid",   bus_a.fire_valid, (x.fire < N) ? 1 : 0);
        check("deadlock",     bus_a.deadlock,   x.dl);
        check("fire_count",   bus_a.fire_count, sat(x.fc, 65535));
        check("idle_count",   bus_a.idle_count, sat(x.ic, 65535));
        check("fire_b",       bus_b.fire,       x.fire);
        check("fire_count_b", bus_b.fire_count, sat(x.fc, 15));
        check("idle_count_b", bus_b.idle_count, sat(x.ic, 15));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] env_exc, pend;
    bus_a.excited = '0; bus_a.allow = '0; bus_a.hold = 1'b0;
    bus_b.excited = '0; bus_b.allow = '0; bus_b.hold = 1'b0;

    // Reset with everything excited, then first firing is index 0.
    repeat (2) step(8'hFF, 8'hFF, 0, 1);
    repeat (3) step(8'hFF, 8'hFF, 0, 0);

    // Round-robin with no-refire, then a single excited bit alternates idle.
    step(8'h00, 8'hFF, 0, 1);
    repeat (9) step(8'h85, 8'hFF, 0, 0);
    repeat (6) step(8'h08, 8'hFF, 0, 0);

    // Closed-loop circuit model: bit i clears one edge after fire == i.
    step(8'h00, 8'hFF, 0, 1);
    env_exc = 8'h0F; pend = 8'h00;
    repeat (8) begin
      env_exc = env_exc & ~pend;
      pend = (m_fire < N) ? (8'd1 << m_fire) : 8'd0;
      step(env_exc, 8'hFF, 0, 0);
    end

    // Allow-mask deadlock, recovery while flag stays sticky, then reset.
    step(8'h00, 8'hFF, 0, 1);
    repeat (18) step(8'h10, 8'hEF, 0, 0);
    repeat (4) step(8'h10, 8'hFF, 0, 0);
    step(8'h10, 8'hFF, 0, 1);
    step(8'h00, 8'hFF, 0, 0);

    // Hold pulse mid-sequence: resumes at next RR index.
    repeat (5) step(8'h85, 8'hFF, 0, 0);
    repeat (3) step(8'h85, 8'hFF, 1, 0);
    repeat (6) step(8'h85, 8'hFF, 0, 0);

    // Saturation on the 4-bit DUT, then a mid-run reset.
    step(8'h00, 8'hFF, 0, 1);
    repeat (20) step(8'h03, 8'hFF, 0, 0);
    step(8'h03, 8'hFF, 0, 1);
    repeat (2) step(8'h03, 8'hFF, 0, 0);

    // Randomized traffic with occasional hold and reset.
    repeat (400) begin
      step(8'($urandom_range(0, 255)),
           ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'hFF,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 99) == 0);
    end
    // Long blocked stretch inside random traffic.
    repeat (20) step(8'h40, 8'hBF, $urandom_range(0, 9) == 0, 0);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fire_scheduler.md
# fire_scheduler

Scheduler that drives the `fire` selector of a generated performance circuit model, playing the environment/driver end of its firing interface. Each clock it picks exactly one excited signal whose precap value differs from its current value, and presents that signal's firing index so the matching DFF toggles at the next edge. Selection is round-robin fair with an environment allow-mask. The block also keeps firing/idle counters and a sticky deadlock flag for performance runs.

## Interface
- `N`, 8: number of firable signals (inputs plus stateful gates/latches); indices 0..N-1.
- `FIREBITS`, 4: width of `fire`; must satisfy 2^FIREBITS >= N+1.
- `CNT_W`, 16: width of the performance counters.
- `BLOCK_LIMIT`, 16: consecutive blocked cycles before `deadlock` asserts.

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `excited`  in  N  bit i = 1 when signal i's precap value differs from its current value.
- `allow`  in  N  environment mask; bit i = 0 forbids firing i this cycle.
- `hold`  in  1  pause; no firing while high.
- `fire`  out  FIREBITS  registered firing index; value N means idle, matching no DFF enable.
- `fire_valid`  out  1  high when `fire` < N.
- `deadlock`  out  1  sticky; blocked for BLOCK_LIMIT consecutive cycles.
- `fire_count`  out  CNT_W  saturating count of firings.
- `idle_count`  out  CNT_W  saturating count of non-hold cycles with no firing.

## Operation
- Reset (`reset`=1 at an edge): `fire`=N, `fire_valid`=0, `deadlock`=0, both counters 0, RR pointer 0, blocked counter 0. Reset overrides `hold` and all other inputs.
- Candidate vector: `cand = excited & allow & ~last`, where `last` is the one-hot of the current `fire` when `fire_valid`=1, else 0. Masking `last` is mandatory. The DFF selected by `fire` only updates at the same edge the scheduler samples, so `excited` still shows that signal as excited. Without the mask it would fire twice, which is a double toggle.
- Selection: the first set bit of `cand` searching from the RR pointer upward, wrapping from N-1 to 0. On a selection of index k: `fire`<=k, `fire_valid`<=1, pointer<=(k+1) mod N (pointer at N-1 wraps to 0), `fire_count` increments and saturates at 2^CNT_W-1.
- If `cand`=0 and `hold`=0: `fire`<=N, `fire_valid`<=0, `idle_count` increments (saturating), pointer unchanged.
- Blocked condition: `hold`=0 and `excited` has a bit set outside `last`, yet `cand`=0.
  - Each blocked cycle increments the blocked counter.
  - Any firing, or a cycle with `excited & ~last` = 0, clears the counter.
  - When the counter reaches BLOCK_LIMIT, `deadlock`<=1. It stays 1 until reset.
- `hold`=1: `fire`<=N, `fire_valid`<=0. Counters, pointer and blocked counter are frozen. `deadlock` is unchanged.
- `deadlock` does not stop scheduling; firing continues if candidates reappear.

## Timing
- One-cycle latency: `fire` reflects the `excited`/`allow`/`hold` values sampled at the previous edge.
- At most one firing per cycle. The same index is never valid in two consecutive cycles.
- Counters update at the same edge as `fire` and are visible one cycle after the decision.
- `deadlock` rises at the edge that completes the BLOCK_LIMIT-th consecutive blocked cycle.

## Test plan
- Reset values: assert `reset` 2 cycles with `excited`=0xFF, `allow`=0xFF → during and after reset edge `fire`=8, `fire_valid`=0, counters 0, `deadlock`=0. First post-reset firing is index 0.
- Round-robin with no-refire: hold `excited`=0x85, `allow`=0xFF, bench never clears → `fire` sequence 0,2,7,0,2,7…; `fire_count` increments every cycle. Then `excited`=0x08 held → 3, idle, 3, idle…; `idle_count` increments on idle cycles.
- Bench model of the target circuit: bit i clears one edge after `fire`=i. Start `excited`=0x0F → fires 0,1,2,3 on four consecutive cycles, then idle; `fire_count`=4.
- Allow-mask deadlock: `excited`=0x10, `allow`=0xEF → `deadlock` rises after exactly 16 cycles. Then set `allow`=0xFF → fires 4 while `deadlock` stays 1. Reset → `deadlock`=0.
- Hold: while firing the 0x85 pattern, pulse `hold` 3 cycles → `fire`=8 for those 3 cycles, counters frozen. The sequence resumes at the next RR index, not at 0.
- Saturation: CNT_W=4, `excited`=0x03 held for 20 cycles → `fire_count` stops at 15. Mid-run reset → all outputs return to reset values at the next edge.
